// File: rtl/ahb_chk_pkg.sv
// ahb_chk_pkg: shared AHB-Lite encodings, rule indices and burst address helpers
package ahb_chk_pkg;
    typedef enum logic [1:0] {T_IDLE, T_BUSY, T_NONSEQ, T_SEQ} htrans_e;
    typedef enum logic [2:0] {HB_SINGLE, HB_INCR, HB_WRAP4, HB_INCR4, HB_WRAP8, HB_INCR8, HB_WRAP16, HB_INCR16} hburst_e;
    typedef enum logic [1:0] {B_IDLE, B_ACTIVE, B_BUSY} bstate_e;
    localparam int RULE_ALIGN       = 0;
    localparam int RULE_IDLE_SEQ    = 1;
    localparam int RULE_SINGLE_BUSY = 2;
    localparam int RULE_WAIT_STABLE = 3;
    localparam int RULE_SEQ_ADDR    = 4;
    localparam int RULE_BURST_LEN   = 5;
    localparam int RULE_KB_CROSS    = 6;
    localparam int RULE_ERR_RESP    = 7;
    function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
        return (hburst == HB_SINGLE) ? 5'd1 : (hburst == HB_INCR) ? 5'd0 : 5'd2 << hburst[2:1];
    endfunction
    function automatic logic [63:0] next_addr(input logic [63:0] addr, input logic [2:0] hsize, input logic [2:0] hburst);
        logic [63:0] incr;
        logic [63:0] mask;
        incr = 64'd1 << hsize;
        mask = (incr << ({1'b0, hburst[2:1]} + 3'd1)) - 64'd1;
        return (hburst[0] || hburst == HB_SINGLE) ? addr + incr : (addr & ~mask) | ((addr + incr) & mask);
    endfunction
endpackage

// File: rtl/ahb_burst_tracker.sv
// ahb_burst_tracker: burst FSM, beat counter, expected next address and previous beat address
module ahb_burst_tracker
    import ahb_chk_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int SIZE_W = 3
) (
    input  logic              i_hclk,
    input  logic              i_hreset,
    input  logic [ADDR_W-1:0] i_haddr,
    input  logic [2:0]        i_hburst,
    input  logic [SIZE_W-1:0] i_hsize,
    input  logic [1:0]        i_htrans,
    input  logic              i_hready,
    input  logic              i_hresp,
    output bstate_e           o_state,
    output logic [4:0]        o_beat_cnt,
    output logic [4:0]        o_len,
    output logic [ADDR_W-1:0] o_exp_addr,
    output logic [ADDR_W-1:0] o_last_addr,
    output logic              o_incr,
    output logic              o_done
);
    bstate_e           r_state, w_state_n;
    logic [4:0]        r_beat, w_beat_n, r_len, w_len_n, w_beat_inc;
    logic [ADDR_W-1:0] r_exp, w_exp_n, r_last, w_last_n, w_nxt;
    logic [2:0]        r_burst, w_burst_n;
    logic              r_done, w_done_n, w_in_burst, w_last_beat;
    logic [63:0]       w_nxt64;

    assign w_in_burst  = r_state != B_IDLE;
    assign w_beat_inc  = (r_beat >= 5'd16) ? 5'd16 : r_beat + 5'd1;
    assign w_last_beat = (r_len != 5'd0) && (w_beat_inc >= r_len);
    assign w_nxt64     = next_addr(64'(i_haddr), 3'(i_hsize), (i_htrans == T_NONSEQ) ? i_hburst : r_burst);
    assign w_nxt       = w_nxt64[ADDR_W-1:0];

    always_comb begin
        w_state_n = r_state;
        w_beat_n  = r_beat;
        w_len_n   = r_len;
        w_exp_n   = r_exp;
        w_last_n  = r_last;
        w_burst_n = r_burst;
        w_done_n  = i_hready ? 1'b0 : r_done;
        if (i_hready && i_hresp)
            w_state_n = B_IDLE;
        else if (i_hready && i_htrans == T_NONSEQ) begin
            w_state_n = (i_hburst != HB_SINGLE) ? B_ACTIVE : B_IDLE;
            w_beat_n  = 5'd1;
            w_len_n   = burst_beats(i_hburst);
            w_exp_n   = w_nxt;
            w_last_n  = i_haddr;
            w_burst_n = i_hburst;
        end else if (i_hready && w_in_burst && i_htrans == T_SEQ) begin
            w_beat_n  = w_beat_inc;
            w_exp_n   = w_nxt;
            w_last_n  = i_haddr;
            w_done_n  = w_last_beat;
            w_state_n = w_last_beat ? B_IDLE : B_ACTIVE;
        end else if (i_hready && w_in_burst && i_htrans == T_BUSY)
            w_state_n = B_BUSY;
        else if (i_hready && i_htrans == T_IDLE)
            w_state_n = B_IDLE;
    end

    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            r_state <= B_IDLE;
            r_beat  <= '0;
            r_len   <= '0;
            r_exp   <= '0;
            r_last  <= '0;
            r_burst <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_beat  <= w_beat_n;
            r_len   <= w_len_n;
            r_exp   <= w_exp_n;
            r_last  <= w_last_n;
            r_burst <= w_burst_n;
            r_done  <= w_done_n;
        end
    end

    assign o_state     = r_state;
    assign o_beat_cnt  = r_beat;
    assign o_len       = r_len;
    assign o_exp_addr  = r_exp;
    assign o_last_addr = r_last;
    assign o_incr      = r_burst[0];
    assign o_done      = r_done;
endmodule

// File: rtl/ahb_lite_protocol_checker.sv
// ahb_lite_protocol_checker: passive AHB-Lite rule checker with pulses, sticky flags, counter and first capture
module ahb_lite_protocol_checker
    import ahb_chk_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int SIZE_W      = 3,
    parameter int CNT_W       = 16,
    parameter int KB_BOUNDARY = 1024
) (
    input  logic              i_hclk,
    input  logic              i_hreset,
    input  logic [ADDR_W-1:0] i_haddr,
    input  logic [2:0]        i_hburst,
    input  logic [SIZE_W-1:0] i_hsize,
    input  logic [1:0]        i_htrans,
    input  logic              i_hwrite,
    input  logic              i_hready,
    input  logic              i_hresp,
    input  logic [7:0]        i_chk_en,
    input  logic              i_clr,
    output logic [7:0]        o_viol_pulse,
    output logic [7:0]        o_viol_sticky,
    output logic [CNT_W-1:0]  o_viol_cnt,
    output logic              o_first_valid,
    output logic [2:0]        o_first_id,
    output logic [ADDR_W-1:0] o_first_addr,
    output logic              o_burst_active,
    output logic [4:0]        o_beat_cnt
);
    localparam int KB_LOG = $clog2(KB_BOUNDARY);

    bstate_e           w_state;
    logic [4:0]        w_len;
    logic [ADDR_W-1:0] w_exp_addr, w_last_addr, w_amask;
    logic              w_incr, w_done, w_acc_seq, w_in_burst;
    logic [7:0]        w_rule, w_viol;
    logic [2:0]        w_first_id;
    logic [ADDR_W-1:0] r_p_addr;
    logic [2:0]        r_p_burst;
    logic [SIZE_W-1:0] r_p_size;
    logic [1:0]        r_p_trans;
    logic              r_p_write, r_p_ready, r_p_resp;
    logic [7:0]        r_pulse, r_sticky;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_fvalid;
    logic [2:0]        r_fid;
    logic [ADDR_W-1:0] r_faddr;

    ahb_burst_tracker #(.ADDR_W(ADDR_W), .SIZE_W(SIZE_W)) u_trk (
        .i_hclk      (i_hclk),
        .i_hreset    (i_hreset),
        .i_haddr     (i_haddr),
        .i_hburst    (i_hburst),
        .i_hsize     (i_hsize),
        .i_htrans    (i_htrans),
        .i_hready    (i_hready),
        .i_hresp     (i_hresp),
        .o_state     (w_state),
        .o_beat_cnt  (o_beat_cnt),
        .o_len       (w_len),
        .o_exp_addr  (w_exp_addr),
        .o_last_addr (w_last_addr),
        .o_incr      (w_incr),
        .o_done      (w_done)
    );

    assign w_in_burst = w_state != B_IDLE;
    assign w_acc_seq  = i_hready && i_htrans == T_SEQ && w_in_burst;
    assign w_amask    = (ADDR_W'(1) << i_hsize) - ADDR_W'(1);

    always_comb begin
        w_rule = '0;
        w_rule[RULE_ALIGN]       = i_htrans[1] && |(i_haddr & w_amask);
        w_rule[RULE_IDLE_SEQ]    = !w_in_burst && (i_htrans == T_SEQ || i_htrans == T_BUSY);
        w_rule[RULE_SINGLE_BUSY] = i_htrans == T_BUSY && i_hburst == HB_SINGLE;
        w_rule[RULE_WAIT_STABLE] = !r_p_ready && r_p_trans[1] && !r_p_resp &&
            ({i_haddr, i_hburst, i_hsize, i_hwrite, i_htrans} != {r_p_addr, r_p_burst, r_p_size, r_p_write, r_p_trans});
        w_rule[RULE_SEQ_ADDR]    = w_acc_seq && i_haddr != w_exp_addr;
        // An ERROR response legitimately cancels the rest of a fixed-length burst
        w_rule[RULE_BURST_LEN]   = (w_in_burst && w_len != 5'd0 && i_hready && !i_hresp &&
            (i_htrans == T_NONSEQ || i_htrans == T_IDLE) && o_beat_cnt < w_len) ||
            (w_done && i_hready && i_htrans == T_SEQ);
        w_rule[RULE_KB_CROSS]    = w_acc_seq && w_incr && ((i_haddr >> KB_LOG) != (w_last_addr >> KB_LOG));
        w_rule[RULE_ERR_RESP]    = i_hresp && i_hready && !(r_p_resp && !r_p_ready);
    end

    assign w_viol = w_rule & i_chk_en;

    always_comb begin
        w_first_id = 3'd0;
        for (int k = 7; k >= 0; k--)
            if (w_viol[k]) w_first_id = 3'(k);
    end

    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            r_p_addr  <= '0;
            r_p_burst <= '0;
            r_p_size  <= '0;
            r_p_trans <= '0;
            r_p_write <= 1'b0;
            r_p_ready <= 1'b0;
            r_p_resp  <= 1'b0;
        end else begin
            r_p_addr  <= i_haddr;
            r_p_burst <= i_hburst;
            r_p_size  <= i_hsize;
            r_p_trans <= i_htrans;
            r_p_write <= i_hwrite;
            r_p_ready <= i_hready;
            r_p_resp  <= i_hresp;
        end
    end

    always_ff @(posedge i_hclk) begin
        if (i_hreset || i_clr) begin
            r_pulse  <= '0;
            r_sticky <= '0;
            r_cnt    <= '0;
            r_fvalid <= 1'b0;
            r_fid    <= '0;
            r_faddr  <= '0;
        end else begin
            r_pulse  <= w_viol;
            r_sticky <= r_sticky | w_viol;
            r_cnt    <= (|w_viol && r_cnt != '1) ? r_cnt + CNT_W'(1) : r_cnt;
            if (|w_viol && !r_fvalid) begin
                r_fvalid <= 1'b1;
                r_fid    <= w_first_id;
                r_faddr  <= i_haddr;
            end
        end
    end

    assign o_viol_pulse   = r_pulse;
    assign o_viol_sticky  = r_sticky;
    assign o_viol_cnt     = r_cnt;
    assign o_first_valid  = r_fvalid;
    assign o_first_id     = r_fid;
    assign o_first_addr   = r_faddr;
    assign o_burst_active = w_in_burst;
endmodule

// File: doc/ahb_lite_protocol_checker.md
Name: ahb_lite_protocol_checker

Overview:
Parametrised, synthesizable AHB-Lite bus protocol checker; the RTL successor to the interface-level property set. Passively samples one master/slave AHB-Lite segment and tracks burst state with a beat-counting FSM. Checks eight protocol rules, each individually enableable. Reports per-cycle violation pulses, sticky flags, a saturating violation count and first-violation capture. Sits beside the bus in the testbench top or an FPGA debug build; it never drives the bus.

Parameters:
ADDR_W, 32, haddr width
SIZE_W, 3, hsize width
CNT_W, 16, width of the saturating total-violation counter
KB_BOUNDARY, 1024, byte boundary that INCR bursts must not cross (power of two)

Ports:
hclk  in  1  bus clock
hreset  in  1  synchronous active-high reset
haddr  in  ADDR_W  sampled address
hburst  in  3  sampled burst type (0 SINGLE, 1 INCR, 2/3 WRAP4/INCR4, 4/5 WRAP8/INCR8, 6/7 WRAP16/INCR16)
hsize  in  SIZE_W  sampled transfer size
htrans  in  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
hwrite  in  1  sampled direction
hready  in  1  bus-level ready (slave HREADYOUT)
hresp  in  1  0 OKAY, 1 ERROR
chk_en  in  8  per-rule enable mask
clr  in  1  synchronous clear of sticky flags, counter and capture
viol_pulse  out  8  one-cycle per-rule violation flags
viol_sticky  out  8  sticky OR of viol_pulse
viol_cnt  out  CNT_W  saturating count of cycles with any violation
first_valid  out  1  first-violation capture valid
first_id  out  3  lowest-numbered rule flagged in the first violating cycle
first_addr  out  ADDR_W  haddr in that cycle
burst_active  out  1  FSM not in B_IDLE
beat_cnt  out  5  beats accepted in the current burst

Behaviour:
- Clock/reset: single clock hclk. Synchronous active-high reset hreset. While hreset=1, every output is 0 and the FSM is B_IDLE. clr has the same effect on viol_sticky, viol_cnt and first_*, but not on the FSM.
- Latency: a rule is evaluated on the inputs sampled at posedge N; viol_pulse is registered and visible after posedge N. Pulses are masked by chk_en, and the mask applies to every output.
- An address phase is accepted when hready=1 and htrans is NONSEQ or SEQ.
- FSM states:
  - B_IDLE -> B_ACTIVE on an accepted NONSEQ with hburst!=SINGLE. beat_cnt loads 1, and beat length and expected next address are latched.
  - B_ACTIVE -> B_BUSY on BUSY with hready=1.
  - B_BUSY -> B_ACTIVE on SEQ.
  - B_ACTIVE -> B_IDLE when an accepted SEQ completes a fixed-length burst, or on IDLE/NONSEQ. A NONSEQ re-enters via the NONSEQ rule.
  - ERROR response (hresp=1, hready=1) -> B_IDLE.
- Expected next address:
  - INCR types: addr + 2^hsize.
  - WRAP types: wrap within a (beats * 2^hsize)-byte aligned window.
- beat_cnt saturates at 16. INCR (undefined length) has no length check.
- Rule 0 ALIGN: NONSEQ/SEQ with haddr mod 2^hsize != 0.
- Rule 1 IDLE_SEQ: SEQ or BUSY sampled while in B_IDLE.
- Rule 2 SINGLE_BUSY: BUSY with hburst=SINGLE.
- Rule 3 WAIT_STABLE: previous cycle had hready=0 and htrans NONSEQ/SEQ, and the current haddr/hburst/hsize/hwrite/htrans differ from it. Exempt when hresp=1 in the previous cycle.
- Rule 4 SEQ_ADDR: accepted SEQ with haddr != expected address.
- Rule 5 BURST_LEN: fixed-length burst ended by NONSEQ/IDLE before beat_cnt reaches its length, or a SEQ after the last beat.
- Rule 6 KB_CROSS: accepted SEQ of an INCR burst whose haddr/KB_BOUNDARY differs from the previous beat's.
- Rule 7 ERR_RESP: hresp=1 with hready=1 whose previous cycle was not hresp=1 with hready=0.
- Simultaneous events:
  - Multiple rules in one cycle all pulse.
  - first_id takes the lowest index.
  - viol_cnt increments by 1 per cycle, not per rule, and holds at all-ones.
  - clr and a violation in the same cycle: clr wins and the violation is dropped.
- Reset mid-burst: the FSM returns to B_IDLE. The first SEQ after reset is flagged by Rule 1.

Decomposition:
- Shared package ahb_chk_pkg holds:
  - htrans/hburst enums and rule index constants RULE_ALIGN..RULE_ERR_RESP;
  - function burst_beats(hburst) returning 1/0(undef)/4/8/16;
  - function next_addr(addr, hsize, hburst).
- One sub-module, ahb_burst_tracker, owns the FSM, beat_cnt and the expected address. The top holds the rule logic, sticky flags, counter and capture.

Test Plan:
- Legal INCR4 word burst 0x100,0x104,0x108,0x10C with hready=1, all chk_en=0xFF -> viol_sticky=0, beat_cnt reaches 4, burst_active drops after the 4th beat.
- WRAP4 word burst from 0x38 -> expects 0x3C,0x30,0x34. Driving 0x40 as 2nd beat -> viol_pulse[4]=1 one cycle, first_id=4, first_addr=0x40, viol_cnt=1.
- NONSEQ 0x200 hsize=2 with hready=0 for 2 cycles, haddr changed to 0x204 in the wait -> viol_pulse[3]=1. Same with hresp=1 in the previous cycle -> no flag.
- INCR8 ended by NONSEQ after 3 beats -> viol_pulse[5]=1. Re-run with chk_en[5]=0 -> no pulse, no sticky, viol_cnt unchanged.
- Single-cycle ERROR (hresp=1, hready=1 with no preceding hresp=1 hready=0 cycle) -> viol_pulse[7]=1. Proper two-cycle ERROR -> no flag, FSM returns to B_IDLE.
- Misaligned NONSEQ 0x3FE hsize=2 together with clr=1 -> no sticky. Hold viol_cnt at 0xFFFF and violate again -> stays 0xFFFF. Assert hreset mid-INCR16 -> all outputs 0 next cycle.
